// File: rtl/fixp_acc_pkg.sv
// rtl/fixp_acc_pkg.sv - shared types, widths and overflow rule for the fixp_acc datapath
package fixp_acc_pkg;

    localparam int FIXP_WIDTH = 128;
    localparam int FIXP_SEG_W = 32;
    localparam int FIXP_TAG_W = 16;

    typedef struct packed {
        logic [FIXP_WIDTH-1:0] a;
        logic [FIXP_WIDTH-1:0] b_eff;
        logic                  cin;
        logic [FIXP_TAG_W-1:0] tag;
        logic                  valid;
    } fixp_beat_t;

    // Same-sign operands whose result sign differs from them.
    function automatic logic fixp_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/fixp_seg_stage.sv
// rtl/fixp_seg_stage.sv - one SEG_W-bit segment adder with carry, valid and skew registers
module fixp_seg_stage #(
    parameter int WIDTH = 128,
    parameter int SEG_W = 32,
    parameter int TAG_W = 16,
    parameter int K     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_carry,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic [TAG_W-1:0] out_tag
);

    logic [SEG_W:0]   seg;
    logic [WIDTH-1:0] sum_nx;

    always_comb begin
        seg = {1'b0, in_a[K*SEG_W +: SEG_W]} + {1'b0, in_b[K*SEG_W +: SEG_W]}
            + {{SEG_W{1'b0}}, in_carry};
        sum_nx = in_sum;
        sum_nx[K*SEG_W +: SEG_W] = seg[SEG_W-1:0];
    end

    // Operands keep travelling so later segments and the sign bits stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_sum   <= '0;
            out_carry <= 1'b0;
            out_tag   <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_a     <= in_a;
            out_b     <= in_b;
            out_sum   <= sum_nx;
            out_carry <= seg[SEG_W];
            out_tag   <= in_tag;
        end
    end

endmodule

// File: rtl/fixp_pipe_adder.sv
// rtl/fixp_pipe_adder.sv - segmented pipelined add/sub with stream handshake and overflow flag
module fixp_pipe_adder
    import fixp_acc_pkg::*;
#(
    parameter int WIDTH = FIXP_WIDTH,
    parameter int SEG_W = FIXP_SEG_W,
    parameter int TAG_W = FIXP_TAG_W
) (
    input  logic             axis_aclk,
    input  logic             mod_rstn,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_a,
    input  logic [WIDTH-1:0] s_b,
    input  logic             s_sub,
    input  logic             s_cin,
    input  logic [TAG_W-1:0] s_tag,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH:0]   m_sum,
    output logic             m_ovf,
    output logic [TAG_W-1:0] m_tag
);

    localparam int NSEG = WIDTH / SEG_W;

    if ((SEG_W < 1) || (WIDTH % SEG_W != 0)) begin : g_param_err
        $error("fixp_pipe_adder: WIDTH must be a positive multiple of SEG_W");
    end

    logic             v_bus [0:NSEG];
    logic [WIDTH-1:0] a_bus [0:NSEG];
    logic [WIDTH-1:0] b_bus [0:NSEG];
    logic [WIDTH-1:0] s_bus [0:NSEG];
    logic             c_bus [0:NSEG];
    logic [TAG_W-1:0] t_bus [0:NSEG];

    logic en;
    logic rdy_q;

    // Keeps s_ready low until the first clock edge after reset release.
    always_ff @(posedge axis_aclk or negedge mod_rstn) begin
        if (!mod_rstn) rdy_q <= 1'b0;
        else           rdy_q <= 1'b1;
    end

    assign en      = ~m_valid | m_ready;
    assign s_ready = rdy_q & en;

    assign v_bus[0] = s_valid & s_ready;
    assign a_bus[0] = s_a;
    assign b_bus[0] = s_sub ? ~s_b : s_b;
    assign s_bus[0] = '0;
    assign c_bus[0] = s_sub ? ~s_cin : s_cin;
    assign t_bus[0] = s_tag;

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        fixp_seg_stage #(
            .WIDTH (WIDTH),
            .SEG_W (SEG_W),
            .TAG_W (TAG_W),
            .K     (k)
        ) u_stage (
            .clk       (axis_aclk),
            .rst_n     (mod_rstn),
            .en        (en),
            .in_valid  (v_bus[k]),
            .in_a      (a_bus[k]),
            .in_b      (b_bus[k]),
            .in_sum    (s_bus[k]),
            .in_carry  (c_bus[k]),
            .in_tag    (t_bus[k]),
            .out_valid (v_bus[k+1]),
            .out_a     (a_bus[k+1]),
            .out_b     (b_bus[k+1]),
            .out_sum   (s_bus[k+1]),
            .out_carry (c_bus[k+1]),
            .out_tag   (t_bus[k+1])
        );
    end

    assign m_valid = v_bus[NSEG];
    assign m_sum   = {c_bus[NSEG], s_bus[NSEG]};
    assign m_ovf   = fixp_ovf(a_bus[NSEG][WIDTH-1], b_bus[NSEG][WIDTH-1], s_bus[NSEG][WIDTH-1]);
    assign m_tag   = t_bus[NSEG];

endmodule

// File: tb/tb_fixp_pipe_adder.sv
// tb/tb_fixp_pipe_adder.sv - scoreboard bench for fixp_pipe_adder
module tb_fixp_pipe_adder;

    localparam int W    = 128;
    localparam int TW   = 16;
    localparam int NSEG = 4;

    typedef struct {
        logic [W:0]    sum;
        logic          ovf;
        logic [TW-1:0] tag;
        int            acc;
        bit            lat;
    } exp_t;

    logic          axis_aclk = 1'b0;
    logic          mod_rstn  = 1'b0;
    logic          s_valid   = 1'b0;
    logic          s_ready;
    logic [W-1:0]  s_a       = '0;
    logic [W-1:0]  s_b       = '0;
    logic          s_sub     = 1'b0;
    logic          s_cin     = 1'b0;
    logic [TW-1:0] s_tag     = '0;
    logic          m_valid;
    logic          m_ready   = 1'b1;
    logic [W:0]    m_sum;
    logic          m_ovf;
    logic [TW-1:0] m_tag;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t sbq[$];
    bit   bp_on = 1'b0;

    bit            prev_stall = 1'b0;
    logic [W:0]    prev_sum;
    logic          prev_ovf;
    logic [TW-1:0] prev_tag;

    logic [W-1:0] ones, max_pos, min_neg;

    fixp_pipe_adder #(.WIDTH(W), .SEG_W(32), .TAG_W(TW)) dut (
        .axis_aclk (axis_aclk),
        .mod_rstn  (mod_rstn),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_a       (s_a),
        .s_b       (s_b),
        .s_sub     (s_sub),
        .s_cin     (s_cin),
        .s_tag     (s_tag),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_sum     (m_sum),
        .m_ovf     (m_ovf),
        .m_tag     (m_tag)
    );

    always #5 axis_aclk = ~axis_aclk;
    always @(posedge axis_aclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    // Plain wide arithmetic reference: returns {ovf, carry, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sub, input logic cin);
        logic [W-1:0] be;
        logic [W:0]   s;
        be = sub ? ~b : b;
        s  = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sub ? ~cin : cin)};
        return {(a[W-1] == be[W-1]) && (s[W-1] != a[W-1]), s};
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input logic cin, input logic [TW-1:0] tag, input logic [W:0] es,
                        input logic eo, input bit lat, input bit push);
        bit   ok = 1'b0;
        exp_t e;
        s_a = a; s_b = b; s_sub = sub; s_cin = cin; s_tag = tag; s_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge axis_aclk);
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("send_timeout");
        else if (push) begin
            e.sum = es; e.ovf = eo; e.tag = tag; e.acc = cyc; e.lat = lat;
            sbq.push_back(e);
        end
        @(posedge axis_aclk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic send_m(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          input logic cin, input logic [TW-1:0] tag, input bit lat);
        logic [W+1:0] r;
        r = model(a, b, sub, cin);
        send(a, b, sub, cin, tag, r[W:0], r[W+1], lat, 1'b1);
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge axis_aclk);
            if (sbq.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("drain_timeout");
        @(posedge axis_aclk);
        #1;
    endtask

    always @(negedge axis_aclk) begin
        exp_t e;
        if (!mod_rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", {{W{1'b0}}, m_valid}, 1);
                check("stall_sum", m_sum, prev_sum);
                check("stall_ovf", {{W{1'b0}}, m_ovf}, {{W{1'b0}}, prev_ovf});
                check("stall_tag", {{(W+1-TW){1'b0}}, m_tag}, {{(W+1-TW){1'b0}}, prev_tag});
            end
            if (m_valid && !m_ready) check("stall_s_ready", {{W{1'b0}}, s_ready}, 0);
            if (m_valid && m_ready) begin
                if (sbq.size() == 0) fail_now("unexpected_beat");
                else begin
                    e = sbq.pop_front();
                    check("sum", m_sum, e.sum);
                    check("ovf", {{W{1'b0}}, m_ovf}, {{W{1'b0}}, e.ovf});
                    check("tag", {{(W+1-TW){1'b0}}, m_tag}, {{(W+1-TW){1'b0}}, e.tag});
                    if (e.lat) check("latency", (W+1)'(cyc - e.acc), NSEG);
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_sum   = m_sum;
            prev_ovf   = m_ovf;
            prev_tag   = m_tag;
        end
    end

    // Backpressure pattern 1,0,0,1 repeating, one step per cycle.
    initial begin
        int k = 0;
        forever begin
            @(posedge axis_aclk);
            #1;
            if (bp_on) begin
                m_ready = (k % 4 == 0) || (k % 4 == 3);
                k++;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        ones    = '1;
        max_pos = {1'b0, {(W-1){1'b1}}};
        min_neg = {1'b1, {(W-1){1'b0}}};

        s_valid = 1'b1;
        s_a = ones;
        s_b = ones;
        repeat (3) @(negedge axis_aclk);
        check("rst_s_ready", {{W{1'b0}}, s_ready}, 0);
        check("rst_m_valid", {{W{1'b0}}, m_valid}, 0);
        check("rst_m_sum", m_sum, 0);
        check("rst_m_tag", {{(W+1-TW){1'b0}}, m_tag}, 0);
        s_valid  = 1'b0;
        mod_rstn = 1'b1;
        #1;
        check("release_s_ready_low", {{W{1'b0}}, s_ready}, 0);
        @(posedge axis_aclk);
        #1;
        check("release_s_ready_high", {{W{1'b0}}, s_ready}, 1);

        send(ones, 128'd1, 1'b0, 1'b0, 16'h0001, {1'b1, {W{1'b0}}}, 1'b0, 1'b1, 1'b1);
        send(max_pos, 128'd1, 1'b0, 1'b0, 16'h0002, {1'b0, min_neg}, 1'b1, 1'b1, 1'b1);
        send(128'd5, 128'd7, 1'b1, 1'b0, 16'h0003, {1'b0, {(W-1){1'b1}}, 1'b0}, 1'b0, 1'b1, 1'b1);
        send(128'd10, 128'd3, 1'b1, 1'b1, 16'h0004, {1'b1, 128'd6}, 1'b0, 1'b1, 1'b1);
        send(min_neg, min_neg, 1'b0, 1'b0, 16'h0005, {1'b1, {W{1'b0}}}, 1'b1, 1'b1, 1'b1);
        send(min_neg, 128'd1, 1'b1, 1'b0, 16'h0006, {1'b1, max_pos}, 1'b1, 1'b1, 1'b1);
        send(128'h1234, 128'd1, 1'b0, 1'b1, 16'h0007, {1'b0, 128'h1236}, 1'b0, 1'b1, 1'b1);
        send(128'hABCD, 128'hABCD, 1'b1, 1'b0, 16'h0008, {1'b1, {W{1'b0}}}, 1'b0, 1'b1, 1'b1);
        drain();

        bp_on = 1'b1;
        for (int i = 0; i < 8; i++)
            send_m({4{32'hFFFF_FFF8}} + 128'(i), {96'h0, 32'h10 + 32'(i)}, i[0], i[1],
                   16'(i), 1'b0);
        drain();
        bp_on = 1'b0;
        m_ready = 1'b1;
        drain();

        for (int i = 0; i < 8; i++)
            send_m({32'h8000_0000, 96'h0} - 128'(i * 3), {4{32'h0000_0001}} << i, i[0],
                   i[2], 16'(16'h100 + i), 1'b1);
        drain();

        for (int i = 0; i < 3; i++)
            send(128'(i), 128'(i), 1'b0, 1'b0, 16'hDEAD, '0, 1'b0, 1'b0, 1'b0);
        mod_rstn = 1'b0;
        @(posedge axis_aclk);
        @(negedge axis_aclk);
        mod_rstn = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge axis_aclk);
            check("post_reset_idle", {{W{1'b0}}, m_valid}, 0);
        end
        @(posedge axis_aclk);
        #1;
        send(128'h55, 128'h22, 1'b0, 1'b0, 16'h0BEE, {1'b0, 128'h77}, 1'b0, 1'b1, 1'b1);
        drain();

        check("queue_empty", (W+1)'(sbq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
